port_rd_scheduler: RTL and testbench
====================================

PORT_RD_SCHEDULER -- requirements
Module: port_rd_scheduler

Interface
REQ-001 SHALL have parameter NUM_Q, default 8, meaning number of priority queues per read port.
REQ-002 SHALL have parameter DATA_W, default 16, meaning memory/transfer word width.
REQ-003 SHALL have parameter LEN_W, default 10, meaning packet length field width (words minus 1).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sched_mode  input  1  0 = strict priority (highest index wins), 1 = round-robin.
REQ-007 SHALL have port rd_ready  input  1  downstream port accepts a new packet.
REQ-008 SHALL have port q_nonempty  input  NUM_Q  per-queue packet-available flags.
REQ-009 SHALL have port pop_vld  output  1  dequeue request to queue manager.
REQ-010 SHALL have port pop_qid  output  log2(NUM_Q)  queue being dequeued.
REQ-011 SHALL have port pop_ack  input  1  queue manager returns packet descriptor this cycle.
REQ-012 SHALL have port pop_addr  input  16  first word address of the packet.
REQ-013 SHALL have port pop_len  input  LEN_W  packet length in words minus 1 (1..1024 words).
REQ-014 SHALL have port mem_rd_en  output  1  memory read strobe, one word per cycle.
REQ-015 SHALL have port mem_rd_addr  output  16  memory read address.
REQ-016 SHALL have port mem_rd_data  input  DATA_W  read data, valid one cycle after mem_rd_en.
REQ-017 SHALL have ports xfer_data_vld (1), xfer_data (DATA_W), end_of_packet (1), all outputs, toward the port read frontend.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, XFER.
REQ-019 IDLE -> REQ when rd_ready=1 and |q_nonempty=1; selected queue index latched that edge; q_nonempty ignored outside IDLE.
REQ-020 Strict mode: select highest set index of q_nonempty.
REQ-021 Round-robin mode: select first set index strictly after rr_ptr, wrapping NUM_Q-1 -> 0; rr_ptr resets to NUM_Q-1 (first grant favours queue 0).
REQ-022 rr_ptr SHALL update to the latched index on pop_ack in both modes.
REQ-023 REQ: pop_vld=1, pop_qid=latched index, held until pop_ack; pop_ack outside REQ ignored.
REQ-024 REQ -> XFER on pop_ack; pop_addr loaded to address register, pop_len loaded to down-counter.
REQ-025 XFER: mem_rd_en=1 every cycle, mem_rd_addr = address register, address +1 per cycle, wraps 0xFFFF -> 0x0000.
REQ-026 XFER: counter decrements each cycle; on cycle with counter==0 last read issued and FSM -> IDLE.
REQ-027 xfer_data_vld SHALL equal mem_rd_en delayed one cycle; xfer_data SHALL be mem_rd_data unregistered.
REQ-028 end_of_packet SHALL be 1 exactly on the xfer_data_vld cycle carrying the last word, else 0.
REQ-029 pop_len=0 SHALL produce a single-word packet with xfer_data_vld and end_of_packet both high for one cycle.
REQ-030 Minimum packet-to-packet gap: one IDLE plus one REQ cycle (plus pop_ack wait); no overlap of packets on xfer outputs.
REQ-031 rd_ready deassertion in REQ/XFER SHALL NOT abort the packet.
REQ-032 sched_mode sampled only in IDLE at selection time.

Reset
REQ-033 On rst_n=0 (asynchronous): FSM=IDLE, pop_vld=0, mem_rd_en=0, xfer_data_vld=0, end_of_packet=0, counter=0, address=0, rr_ptr=NUM_Q-1.
REQ-034 Reset mid-REQ/XFER SHALL abandon the packet; no further pop_vld or mem_rd_en until a new IDLE selection.

Structure
REQ-035 NUM_Q, DATA_W, LEN_W defaults and the FSM state enum SHALL live in shared package port_rd_pkg.
REQ-036 Queue selection (strict/round-robin, combinational, with rr_ptr input) SHALL be sub-module port_rd_picker.

Verification
REQ-037 q_nonempty=8'b1001_0010, mode 0, rd_ready=1 -> pop_qid=7.
REQ-038 Mode 1, rr_ptr=4, q_nonempty=8'b0000_0110 -> pop_qid=1; after ack next grant with same flags -> 2.
REQ-039 pop_addr=0xFFFE, pop_len=3 -> addrs 0xFFFE,0xFFFF,0x0000,0x0001; 4 vld words, end_of_packet on 4th.
REQ-040 pop_len=0 -> one mem_rd_en, one xfer_data_vld cycle with end_of_packet=1.
REQ-041 pop_ack delayed 5 cycles -> pop_vld high 5+ cycles, pop_qid stable, no mem_rd_en meanwhile.
REQ-042 rst_n low during XFER word 2 of 8 -> all outputs 0 immediately; no further reads until new request.

Source files
------------

// File: rtl/port_rd_pkg.sv
// Shared defaults and FSM encoding for the port read scheduler.
package port_rd_pkg;

    localparam int NUM_Q_DEF  = 8;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } rd_state_t;

endpackage

// File: rtl/port_rd_picker.sv
// Combinational queue picker: strict priority (highest index) or round-robin after rr_ptr.
module port_rd_picker
    import port_rd_pkg::*;
#(
    parameter int NUM_Q  = NUM_Q_DEF,
    localparam int QID_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
)(
    input  logic             mode,
    input  logic [NUM_Q-1:0] req,
    input  logic [QID_W-1:0] rr_ptr,
    output logic             any,
    output logic [QID_W-1:0] qid
);

    logic             found;
    logic [QID_W-1:0] idx;

    assign any = |req;

    always_comb begin
        qid   = '0;
        found = 1'b0;
        idx   = '0;
        if (!mode) begin
            for (int i = 0; i < NUM_Q; i++) begin
                if (req[i]) qid = QID_W'(i);
            end
        end else begin
            // Scan starts one past rr_ptr so the last winner is considered last.
            for (int k = 1; k <= NUM_Q; k++) begin
                idx = QID_W'((int'(rr_ptr) + k) % NUM_Q);
                if (!found && req[idx]) begin
                    found = 1'b1;
                    qid   = idx;
                end
            end
        end
    end

endmodule

// File: rtl/port_rd_scheduler.sv
// Read-port scheduler: picks a queue, pops a descriptor, then streams the packet from memory.
//   state   | meaning
//   IDLE    | waiting for rd_ready and a non-empty queue; selection latched on exit
//   REQ     | pop_vld held with latched qid until pop_ack
//   XFER    | one memory read per cycle until the length counter hits zero
module port_rd_scheduler
    import port_rd_pkg::*;
#(
    parameter int NUM_Q  = NUM_Q_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    localparam int QID_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sched_mode,
    input  logic              rd_ready,
    input  logic [NUM_Q-1:0]  q_nonempty,
    output logic              pop_vld,
    output logic [QID_W-1:0]  pop_qid,
    input  logic              pop_ack,
    input  logic [15:0]       pop_addr,
    input  logic [LEN_W-1:0]  pop_len,
    output logic              mem_rd_en,
    output logic [15:0]       mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              xfer_data_vld,
    output logic [DATA_W-1:0] xfer_data,
    output logic              end_of_packet
);

    rd_state_t        state, state_nxt;
    logic [QID_W-1:0] sel_q;
    logic [QID_W-1:0] rr_ptr;
    logic [15:0]      addr_q;
    logic [LEN_W-1:0] cnt_q;
    logic             xfer_vld_q;
    logic             eop_q;
    logic             pick_any;
    logic [QID_W-1:0] pick_qid;
    logic             start;
    logic             last_rd;

    port_rd_picker #(.NUM_Q(NUM_Q)) u_picker (
        .mode   (sched_mode),
        .req    (q_nonempty),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .qid    (pick_qid)
    );

    assign start   = (state == ST_IDLE) && rd_ready && pick_any;
    assign last_rd = (state == ST_XFER) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)   state_nxt = ST_REQ;
            ST_REQ:  if (pop_ack) state_nxt = ST_XFER;
            ST_XFER: if (last_rd) state_nxt = ST_IDLE;
            default:              state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= '0;
            rr_ptr     <= QID_W'(NUM_Q - 1);
            addr_q     <= '0;
            cnt_q      <= '0;
            xfer_vld_q <= 1'b0;
            eop_q      <= 1'b0;
        end else begin
            xfer_vld_q <= mem_rd_en;
            eop_q      <= last_rd;
            case (state)
                ST_IDLE: if (start) sel_q <= pick_qid;
                ST_REQ: begin
                    if (pop_ack) begin
                        addr_q <= pop_addr;
                        cnt_q  <= pop_len;
                        rr_ptr <= sel_q;
                    end
                end
                ST_XFER: begin
                    addr_q <= addr_q + 16'd1;
                    if (cnt_q != '0) cnt_q <= cnt_q - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign pop_vld       = (state == ST_REQ);
    assign pop_qid       = sel_q;
    assign mem_rd_en     = (state == ST_XFER);
    assign mem_rd_addr   = addr_q;
    assign xfer_data_vld = xfer_vld_q;
    assign xfer_data     = mem_rd_data;
    assign end_of_packet = eop_q;

endmodule

// File: tb/tb_port_rd_scheduler.sv
// Scoreboard bench for port_rd_scheduler: directed packets, monitor checks grants, reads and data.
module tb_port_rd_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sched_mode;
    logic        rd_ready;
    logic [7:0]  q_nonempty;
    logic        pop_vld;
    logic [2:0]  pop_qid;
    logic        pop_ack;
    logic [15:0] pop_addr;
    logic [9:0]  pop_len;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        xfer_data_vld;
    logic [15:0] xfer_data;
    logic        end_of_packet;

    typedef struct packed {
        logic [15:0] data;
        logic        eop;
    } word_t;

    int          exp_qid_q[$];
    logic [15:0] exp_addr_q[$];
    word_t       exp_word_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    port_rd_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sched_mode    (sched_mode),
        .rd_ready      (rd_ready),
        .q_nonempty    (q_nonempty),
        .pop_vld       (pop_vld),
        .pop_qid       (pop_qid),
        .pop_ack       (pop_ack),
        .pop_addr      (pop_addr),
        .pop_len       (pop_len),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .xfer_data_vld (xfer_data_vld),
        .xfer_data     (xfer_data),
        .end_of_packet (end_of_packet)
    );

    always #5 clk = ~clk;

    // Memory returns a recognisable function of the address one cycle after the strobe.
    initial mem_rd_data = 16'h0000;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_rd_addr ^ 16'h5A5A;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected or missing event at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pop_vld && pop_ack) begin
                if (exp_qid_q.size() == 0) fail("pop_unexpected");
                else chk("pop_qid", 32'(pop_qid), 32'(exp_qid_q.pop_front()));
            end
            if (mem_rd_en) begin
                if (exp_addr_q.size() == 0) fail("rd_unexpected");
                else chk("rd_addr", 32'(mem_rd_addr), 32'(exp_addr_q.pop_front()));
            end
            if (xfer_data_vld) begin
                if (exp_word_q.size() == 0) fail("xfer_unexpected");
                else begin
                    word_t w;
                    w = exp_word_q.pop_front();
                    chk("xfer_data", 32'(xfer_data), 32'(w.data));
                    chk("xfer_eop", 32'(end_of_packet), 32'(w.eop));
                end
            end else begin
                chk("eop_without_vld", 32'(end_of_packet), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_packet(input logic mode, input logic [7:0] flags, input int exp_qid,
                                input int ack_dly, input logic [15:0] addr, input logic [9:0] len);
        int waited;
        sched_mode = mode;
        q_nonempty = flags;
        rd_ready   = 1'b1;
        exp_qid_q.push_back(exp_qid);
        waited = 0;
        tick();
        while (!pop_vld && waited < 20) begin
            tick();
            waited++;
        end
        if (!pop_vld) begin
            fail("pop_vld_timeout");
            rd_ready = 1'b0;
            return;
        end
        // Selection inputs are now irrelevant until the next IDLE.
        rd_ready   = 1'b0;
        sched_mode = ~mode;
        q_nonempty = ~flags;
        for (int i = 0; i < ack_dly; i++) begin
            chk("wait_pop_vld", 32'(pop_vld), 32'd1);
            chk("wait_pop_qid", 32'(pop_qid), 32'(exp_qid));
            chk("wait_no_rd", 32'(mem_rd_en), 32'd0);
            tick();
        end
        pop_ack  = 1'b1;
        pop_addr = addr;
        pop_len  = len;
        for (int i = 0; i <= int'(len); i++) begin
            logic [15:0] a;
            a = addr + 16'(i);
            exp_addr_q.push_back(a);
            exp_word_q.push_back('{data: a ^ 16'h5A5A, eop: (i == int'(len))});
        end
        tick();
        pop_ack = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_addr_q.size() != 0 || exp_word_q.size() != 0 || exp_qid_q.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        if (exp_addr_q.size() != 0 || exp_word_q.size() != 0 || exp_qid_q.size() != 0) begin
            fail(name);
            exp_addr_q.delete();
            exp_word_q.delete();
            exp_qid_q.delete();
        end
        tick();
        tick();
        chk("idle_pop_vld", 32'(pop_vld), 32'd0);
        chk("idle_rd_en", 32'(mem_rd_en), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        sched_mode = 1'b0;
        rd_ready   = 1'b0;
        q_nonempty = 8'h00;
        pop_ack    = 1'b0;
        pop_addr   = 16'h0000;
        pop_len    = 10'd0;
        #1;
        chk("rst_pop_vld", 32'(pop_vld), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_xfer_vld", 32'(xfer_data_vld), 32'd0);
        chk("rst_eop", 32'(end_of_packet), 32'd0);
        chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Round-robin out of reset: pointer at 7, so queue 0 would be first; 0 is empty -> 1.
        start_packet(1'b1, 8'b1001_0010, 1, 0, 16'h0100, 10'd1);
        wait_drain("drain_rr_first");

        // Strict priority picks 7; address wraps past 0xFFFF.
        start_packet(1'b0, 8'b1001_0010, 7, 0, 16'hFFFE, 10'd3);
        wait_drain("drain_wrap");

        // Single-word packet with a slow pop_ack; leaves rr_ptr at 4.
        start_packet(1'b0, 8'b0001_0000, 4, 5, 16'h1234, 10'd0);
        wait_drain("drain_single");

        // Round-robin from 4 with queues 1,2 ready -> 1, then 2, then 1 again.
        start_packet(1'b1, 8'b0000_0110, 1, 0, 16'h4000, 10'd2);
        wait_drain("drain_rr_a");
        start_packet(1'b1, 8'b0000_0110, 2, 1, 16'h5000, 10'd0);
        wait_drain("drain_rr_b");
        start_packet(1'b1, 8'b0000_0110, 1, 0, 16'h5100, 10'd1);
        wait_drain("drain_rr_c");

        // Strict with lowest queue only.
        start_packet(1'b0, 8'b0000_0001, 0, 2, 16'h6000, 10'd2);
        wait_drain("drain_strict_q0");

        // pop_ack while idle must not start anything.
        pop_ack  = 1'b1;
        pop_addr = 16'h7777;
        pop_len  = 10'd3;
        tick();
        pop_ack = 1'b0;
        tick();
        chk("stray_ack_pop_vld", 32'(pop_vld), 32'd0);
        chk("stray_ack_rd_en", 32'(mem_rd_en), 32'd0);

        // Reset while the second of eight words is being read.
        start_packet(1'b0, 8'b0000_1000, 3, 0, 16'h2000, 10'd7);
        tick();
        chk("pre_rst_rd_addr", 32'(mem_rd_addr), 32'h2001);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pop_vld", 32'(pop_vld), 32'd0);
        chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("mid_rst_xfer_vld", 32'(xfer_data_vld), 32'd0);
        chk("mid_rst_eop", 32'(end_of_packet), 32'd0);
        exp_addr_q.delete();
        exp_word_q.delete();
        exp_qid_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_pop_vld", 32'(pop_vld), 32'd0);
            chk("post_rst_rd_en", 32'(mem_rd_en), 32'd0);
        end

        // rr_ptr must be back at 7: flags {7,0} grant 0, not 7.
        start_packet(1'b1, 8'b1000_0001, 0, 0, 16'h3000, 10'd1);
        wait_drain("drain_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
